rt_pkt_ctl: RTL and testbench
=============================

# rt_pkt_ctl

Per-input-port wormhole packet controller that sits directly upstream of `dec_rt`. It pops flits from the input buffer and presents the head-flit addressing fields to `dec_rt`. It then latches the returned route (port, multicast status, trimmed multicast mask) for the whole packet and rewrites the head's multicast mask. Every flit is steered to the switch-allocation request and/or the local ejection interface, with a fork for multicast-absorb-forward.

## Interface
Parameters:
- `MY_XPOS`, default 0: router X position; passed through to `dec_rt`.
- `MY_YPOS`, default 0: router Y position; passed through to `dec_rt`.
- `FLITW`, default 32: flit width; must be ≥ `F_ADDR0` MSB + 1.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: input buffer has a flit.
- `in_flit`, in, FLITW: head-of-buffer flit.
- `in_ready`, out, 1: pop strobe; the flit is consumed when `in_valid & in_ready`.
- `dec_um_type`, out, 1: to `dec_rt.um_type`.
- `dec_addr0`, out, `UADDR+1: to `dec_rt.addr0`.
- `dec_addr1`, out, `MADDR+1: to `dec_rt.addr1`.
- `dec_port`, in, `PORTW+1: from `dec_rt.port`.
- `dec_addr1_rm`, in, `MADDR+1: from `dec_rt.addr1_rm`.
- `dec_multab_en`, in, `DSTATUS+1: from `dec_rt.multab_en`.
- `fwd_valid`, out, 1: forward request to switch allocator.
- `fwd_port`, out, `PORTW+1: latched output port.
- `fwd_flit`, out, FLITW: flit to forward, with the head rewritten.
- `fwd_ready`, in, 1: allocator/crossbar accepted the flit.
- `ej_valid`, out, 1: local absorb request.
- `ej_flit`, out, FLITW: flit to the local sink, unmodified.
- `ej_ready`, in, 1: local sink accepted the flit.
- `busy`, out, 1: a packet is in progress (state ≠ IDLE).
- `err`, out, 1: sticky protocol error; cleared only by reset.

## Operation
Flit type is `in_flit[F_TYPE]`: 00 body, 01 tail, 10 head, 11 headtail. Head fields are `F_UMT`, `F_ADDR0` and `F_ADDR1`.

The `dec_*` outputs are driven combinationally from `in_flit` at all times. `dec_rt` is purely combinational.

FSM states:
- **IDLE**: `in_ready`=0.
  - On `in_valid` with a head/headtail flit: latch `dec_port`, `dec_multab_en`, `dec_addr1_rm`; capture the flit into the hold register; go to HEAD. The flit is not popped yet.
  - On `in_valid` with a body/tail flit: pop and discard it, set `err`, stay in IDLE.
- **HEAD / BODY**: present the hold flit per the routing mode (below).
  - A side's done bit sets on its handshake (`fwd_valid&fwd_ready`, `ej_valid&ej_ready`). Its valid deasserts the following cycle and is never re-presented for this flit.
  - When all required sides are done (the final handshake counts), pulse `in_ready` to pop, clear the done bits, and advance.
  - Type tail/headtail → IDLE; otherwise → BODY, loading the next flit when `in_valid`.
  - A head arriving in BODY is forwarded as a body flit with no reroute, and sets `err`.

Routing mode, latched per packet:
- `UNICAST`: forward only, unmodified flits.
- `MULTFWD`: forward only; the head's `F_ADDR1` is replaced by the latched `addr1_rm`.
- `MULTABS` with `addr1_rm` ≠ 0: fork to both sides; the forwarded head carries `addr1_rm`, the ejected head is original.
- `MULTABS` with `addr1_rm` = 0: absorb only; `fwd_valid` stays 0.

Other rules:
- When both fork sides accept in the same cycle, pop in that cycle.
- `fwd_port` is constant from HEAD entry until tail pop.

## Timing
- Reset values: state IDLE, done bits 0, `in_ready` 0, `fwd_valid` 0, `ej_valid` 0, `fwd_port` 0, `fwd_flit` 0, `ej_flit` 0, `busy` 0, `err` 0.
- Reset mid-packet abandons the packet; the buffered flit is not popped.
- Latency: head visible in the buffer at cycle N → `fwd_valid`/`ej_valid` at N+1. Minimum pop at N+1.
- Body/tail flits present one cycle after the previous pop. Throughput is 1 flit per 2 cycles; no bypass.
- Valids are registered. Each valid holds with its flit stable until its ready is seen.
- `in_ready` is a single-cycle pulse.
- `dec_*` ports have a combinational path from `in_flit` only.

## Structure
- `define.h` gains `F_TYPE`, `F_UMT`, `F_ADDR0`, `F_ADDR1` ranges and `FT_BODY`/`FT_TAIL`/`FT_HEAD`/`FT_HT`.
- `define.h` keeps the existing `UNICAST`/`MULTFWD`/`MULTABS`, `UADDR`, `MADDR`, `PORTW`, `DSTATUS`.
- `dec_rt` is instantiated at the router level, not inside this block.
- One natural sub-module: `fork_done`, the two-side done-bit tracker (required mask + two handshakes → `all_done`).

## Test plan
- Unicast headtail with addr0=5 at node (0,0): single forward with `fwd_port`=`dec_port`, `ej_valid` never set, pop at cycle N+1.
- MULTFWD 3-flit packet with addr1 bit 9 set at (0,0): forwarded head's `F_ADDR1` equals the original; body and tail use the same port; returns to IDLE after the tail.
- MULTABS at (0,1), addr1 = bits 1 and 5: forwarded head has mask bit 5 only, ejected head is original. With `ej_ready` at N+1 and `fwd_ready` at N+3, pop occurs at N+3 and `ej_valid` drops at N+2.
- MULTABS with mask = own bit only: `ej_valid` only, `fwd_valid` stays 0 throughout.
- Body flit in IDLE: popped, `err`=1. Then a head arrives mid-packet: forwarded as body, port unchanged.
- `rst_` low during BODY: all outputs 0 immediately. After release, the head is re-decoded from scratch.

Source files
------------

// File: rtl/rt_pkt_ctl_pkg.sv
// Shared flit layout, routing-mode encodings and FSM state type for the
// per-port wormhole packet controller.
package rt_pkt_ctl_pkg;

    // Widths of the dec_rt fields (each port is WIDTH+1 bits wide).
    localparam int UADDR   = 3;
    localparam int MADDR   = 15;
    localparam int PORTW   = 2;
    localparam int DSTATUS = 1;

    // Flit field positions; the unicast destination sits highest.
    localparam int F_TYPE_LO  = 0;
    localparam int F_TYPE_HI  = 1;
    localparam int F_UMT      = 2;
    localparam int F_ADDR1_LO = 3;
    localparam int F_ADDR1_HI = F_ADDR1_LO + MADDR;
    localparam int F_ADDR0_LO = F_ADDR1_HI + 1;
    localparam int F_ADDR0_HI = F_ADDR0_LO + UADDR;

    localparam logic [1:0] FT_BODY = 2'b00;
    localparam logic [1:0] FT_TAIL = 2'b01;
    localparam logic [1:0] FT_HEAD = 2'b10;
    localparam logic [1:0] FT_HT   = 2'b11;

    localparam logic [DSTATUS:0] UNICAST = 2'd0;
    localparam logic [DSTATUS:0] MULTFWD = 2'd1;
    localparam logic [DSTATUS:0] MULTABS = 2'd2;

    // S_NEXT: between flits of a packet, waiting for the buffer to show the next one.
    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_NEXT} state_e;

    function automatic logic is_head(input logic [1:0] t);
        return t[1];
    endfunction

    function automatic logic is_tail(input logic [1:0] t);
        return t[0];
    endfunction

endpackage

// File: rtl/rt_pkt_ctl_if.sv
// Buffer, dec_rt, switch-allocation and ejection signals of one input port.
interface rt_pkt_ctl_if
    import rt_pkt_ctl_pkg::*;
#(
    parameter int FLITW = 32
) ();
    logic               in_valid;
    logic [FLITW-1:0]   in_flit;
    logic               in_ready;
    logic               dec_um_type;
    logic [UADDR:0]     dec_addr0;
    logic [MADDR:0]     dec_addr1;
    logic [PORTW:0]     dec_port;
    logic [MADDR:0]     dec_addr1_rm;
    logic [DSTATUS:0]   dec_multab_en;
    logic               fwd_valid;
    logic [PORTW:0]     fwd_port;
    logic [FLITW-1:0]   fwd_flit;
    logic               fwd_ready;
    logic               ej_valid;
    logic [FLITW-1:0]   ej_flit;
    logic               ej_ready;

    modport slave (
        input  in_valid, in_flit, dec_port, dec_addr1_rm, dec_multab_en, fwd_ready, ej_ready,
        output in_ready, dec_um_type, dec_addr0, dec_addr1, fwd_valid, fwd_port, fwd_flit,
               ej_valid, ej_flit
    );

    modport master (
        output in_valid, in_flit, dec_port, dec_addr1_rm, dec_multab_en, fwd_ready, ej_ready,
        input  in_ready, dec_um_type, dec_addr0, dec_addr1, fwd_valid, fwd_port, fwd_flit,
               ej_valid, ej_flit
    );
endinterface

// File: rtl/rt_pkt_ctl_fork_done.sv
// Two-side done tracker: all_done_o rises once every required side has
// handshaken, counting a handshake in the current cycle.
module rt_pkt_ctl_fork_done (
    input  logic clk,
    input  logic rst_,
    input  logic req_f_i,
    input  logic req_e_i,
    input  logic f_hs_i,
    input  logic e_hs_i,
    output logic all_done_o
);
    logic f_done_q, f_done_d;
    logic e_done_q, e_done_d;

    always_comb begin
        all_done_o = (!req_f_i || f_done_q || f_hs_i) && (!req_e_i || e_done_q || e_hs_i);
        f_done_d   = all_done_o ? 1'b0 : (f_done_q || f_hs_i);
        e_done_d   = all_done_o ? 1'b0 : (e_done_q || e_hs_i);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            f_done_q <= 1'b0;
            e_done_q <= 1'b0;
        end else begin
            f_done_q <= f_done_d;
            e_done_q <= e_done_d;
        end
    end
endmodule

// File: rtl/rt_pkt_ctl.sv
// Wormhole packet controller: decodes the head via dec_rt, latches the route
// for the packet and steers every flit to forward and/or local ejection.
module rt_pkt_ctl
    import rt_pkt_ctl_pkg::*;
#(
    parameter int MY_XPOS = 0,
    parameter int MY_YPOS = 0,
    parameter int FLITW   = 32
) (
    input  logic        clk,
    input  logic        rst_,
    rt_pkt_ctl_if.slave bus,
    output logic        busy,
    output logic        err
);
    if (FLITW < F_ADDR0_HI + 1 || MY_XPOS < 0 || MY_YPOS < 0) begin : g_param_chk
        $error("rt_pkt_ctl: FLITW too narrow or negative router position");
    end

    state_e           state_q, state_d;
    logic [PORTW:0]   port_q;
    logic [DSTATUS:0] mode_q;
    logic [MADDR:0]   rm_q;
    logic             fwd_valid_q, ej_valid_q, tail_q, drop_q, drop_d, err_q;
    logic [FLITW-1:0] fwd_flit_q, ej_flit_q, head_fwd;
    logic [1:0]       in_type;
    logic             load_head, load_body, req_f, req_e, dec_req_f, f_hs, e_hs;
    logic             all_done, present;

    assign in_type         = bus.in_flit[F_TYPE_HI:F_TYPE_LO];
    assign bus.dec_um_type = bus.in_flit[F_UMT];
    assign bus.dec_addr0   = bus.in_flit[F_ADDR0_HI:F_ADDR0_LO];
    assign bus.dec_addr1   = bus.in_flit[F_ADDR1_HI:F_ADDR1_LO];

    // Forward side is skipped only when absorb leaves no remaining destinations.
    assign req_f     = (mode_q != MULTABS) || (rm_q != '0);
    assign req_e     = (mode_q == MULTABS);
    assign dec_req_f = (bus.dec_multab_en != MULTABS) || (bus.dec_addr1_rm != '0);
    assign f_hs      = fwd_valid_q && bus.fwd_ready;
    assign e_hs      = ej_valid_q && bus.ej_ready;
    assign present   = (state_q == S_HEAD) || (state_q == S_BODY);
    assign load_head = (state_q == S_IDLE) && bus.in_valid && is_head(in_type);
    assign load_body = (state_q == S_NEXT) && bus.in_valid;
    assign drop_d    = (state_q == S_IDLE) && bus.in_valid && !is_head(in_type) && !drop_q;

    rt_pkt_ctl_fork_done u_done (
        .clk        (clk),
        .rst_       (rst_),
        .req_f_i    (req_f),
        .req_e_i    (req_e),
        .f_hs_i     (f_hs),
        .e_hs_i     (e_hs),
        .all_done_o (all_done)
    );

    always_comb begin
        head_fwd = bus.in_flit;
        if (bus.dec_multab_en == MULTFWD || bus.dec_multab_en == MULTABS)
            head_fwd[F_ADDR1_HI:F_ADDR1_LO] = bus.dec_addr1_rm;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:         if (load_head) state_d = S_HEAD;
            S_HEAD, S_BODY: if (all_done)  state_d = tail_q ? S_IDLE : S_NEXT;
            S_NEXT:         if (load_body) state_d = S_BODY;
            default:        state_d = S_IDLE;
        endcase
    end

    // A stray body/tail in IDLE is popped one cycle after it is seen.
    always_comb begin
        bus.in_ready = (present && all_done) || drop_q;
        busy         = (state_q != S_IDLE);
    end

    assign bus.fwd_valid = fwd_valid_q;
    assign bus.fwd_port  = port_q;
    assign bus.fwd_flit  = fwd_flit_q;
    assign bus.ej_valid  = ej_valid_q;
    assign bus.ej_flit   = ej_flit_q;
    assign err           = err_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            port_q      <= '0;
            mode_q      <= UNICAST;
            rm_q        <= '0;
            fwd_valid_q <= 1'b0;
            ej_valid_q  <= 1'b0;
            fwd_flit_q  <= '0;
            ej_flit_q   <= '0;
            tail_q      <= 1'b0;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            drop_q <= drop_d;
            if (drop_d) err_q <= 1'b1;
            if (f_hs) fwd_valid_q <= 1'b0;
            if (e_hs) ej_valid_q  <= 1'b0;
            if (load_head) begin
                port_q      <= bus.dec_port;
                mode_q      <= bus.dec_multab_en;
                rm_q        <= bus.dec_addr1_rm;
                fwd_flit_q  <= head_fwd;
                ej_flit_q   <= bus.in_flit;
                tail_q      <= is_tail(in_type);
                fwd_valid_q <= dec_req_f;
                ej_valid_q  <= (bus.dec_multab_en == MULTABS);
            end
            // Mid-packet heads travel as plain body flits on the latched route.
            if (load_body) begin
                fwd_flit_q  <= bus.in_flit;
                ej_flit_q   <= bus.in_flit;
                tail_q      <= is_tail(in_type);
                fwd_valid_q <= req_f;
                ej_valid_q  <= req_e;
                if (is_head(in_type)) err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rt_pkt_ctl.sv
// Directed bench for rt_pkt_ctl; dec_rt responses are driven as hand-chosen constants.
module tb_rt_pkt_ctl;
    import rt_pkt_ctl_pkg::*;

    logic clk = 1'b0;
    logic rst_;
    logic busy, err;
    int   total = 0;
    int   bad   = 0;

    rt_pkt_ctl_if #(.FLITW(32)) bus ();

    rt_pkt_ctl #(.MY_XPOS(0), .MY_YPOS(0), .FLITW(32)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus),
        .busy (busy),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic [2:0] p, input logic [1:0] m, input logic [15:0] rm);
        bus.dec_port      = p;
        bus.dec_multab_en = m;
        bus.dec_addr1_rm  = rm;
    endtask

    function automatic logic [31:0] mk(input logic [1:0] t, input logic u, input logic [3:0] a0,
                                       input logic [15:0] a1, input logic [8:0] pl);
        return {pl, a0, a1, u, t};
    endfunction

    logic [31:0] f1, h2, b2, t2, h3, h3f, h4, b5, h5, h5b, t5, h6, b6, h6b;

    initial begin
        f1  = mk(FT_HT,   1'b0, 4'd5, 16'h0000, 9'h1A1);
        h2  = mk(FT_HEAD, 1'b1, 4'd2, 16'h0200, 9'h055);
        b2  = 32'h1234_5670;
        t2  = 32'hCAFE_0001;
        h3  = mk(FT_HT,   1'b1, 4'd0, 16'h0022, 9'h0F0);
        h3f = mk(FT_HT,   1'b1, 4'd0, 16'h0020, 9'h0F0);
        h4  = mk(FT_HT,   1'b1, 4'd0, 16'h0002, 9'h101);
        b5  = 32'h0BAD_0000;
        h5  = mk(FT_HEAD, 1'b0, 4'd7, 16'h0000, 9'h033);
        h5b = mk(FT_HEAD, 1'b0, 4'd1, 16'h0000, 9'h044);
        t5  = 32'h7777_0001;
        h6  = mk(FT_HEAD, 1'b0, 4'd3, 16'h0000, 9'h066);
        b6  = 32'h5555_0000;
        h6b = mk(FT_HT,   1'b0, 4'd2, 16'h0000, 9'h077);

        rst_ = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_flit  = '0;
        bus.fwd_ready = 1'b0;
        bus.ej_ready  = 1'b0;
        dec(3'd0, UNICAST, 16'h0);
        #2;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_fwd_valid", bus.fwd_valid, 0);
        chk("rst_ej_valid", bus.ej_valid, 0);
        chk("rst_fwd_port", bus.fwd_port, 0);
        chk("rst_fwd_flit", bus.fwd_flit, 0);
        chk("rst_ej_flit", bus.ej_flit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        nxt();
        rst_ = 1'b1;

        // Unicast headtail
        nxt();
        bus.in_valid = 1'b1; bus.in_flit = f1; bus.fwd_ready = 1'b1;
        dec(3'd1, UNICAST, 16'h0);
        #1;
        chk("s1_dec_addr0", bus.dec_addr0, 5);
        chk("s1_dec_umt", bus.dec_um_type, 0);
        chk("s1_n_in_ready", bus.in_ready, 0);
        chk("s1_n_fwd_valid", bus.fwd_valid, 0);
        nxt();
        chk("s1_fwd_valid", bus.fwd_valid, 1);
        chk("s1_fwd_port", bus.fwd_port, 1);
        chk("s1_fwd_flit", bus.fwd_flit, f1);
        chk("s1_ej_valid", bus.ej_valid, 0);
        chk("s1_pop", bus.in_ready, 1);
        nxt();
        bus.in_valid = 1'b0; bus.fwd_ready = 1'b0;
        #1;
        chk("s1_busy_end", busy, 0);
        chk("s1_fwd_valid_end", bus.fwd_valid, 0);
        chk("s1_in_ready_end", bus.in_ready, 0);

        // MULTFWD 3-flit packet
        nxt();
        bus.in_valid = 1'b1; bus.in_flit = h2; bus.fwd_ready = 1'b1;
        dec(3'd2, MULTFWD, 16'h0200);
        #1;
        chk("s2_dec_addr1", bus.dec_addr1, 32'h0200);
        chk("s2_dec_umt", bus.dec_um_type, 1);
        nxt();
        dec(3'd5, UNICAST, 16'hFFFF);
        #1;
        chk("s2_head_valid", bus.fwd_valid, 1);
        chk("s2_head_flit", bus.fwd_flit, h2);
        chk("s2_head_port", bus.fwd_port, 2);
        chk("s2_head_pop", bus.in_ready, 1);
        nxt();
        bus.in_flit = b2;
        #1;
        chk("s2_gap_busy", busy, 1);
        chk("s2_gap_valid", bus.fwd_valid, 0);
        chk("s2_gap_ready", bus.in_ready, 0);
        nxt();
        chk("s2_body_valid", bus.fwd_valid, 1);
        chk("s2_body_flit", bus.fwd_flit, b2);
        chk("s2_body_port", bus.fwd_port, 2);
        chk("s2_body_ej", bus.ej_valid, 0);
        chk("s2_body_pop", bus.in_ready, 1);
        nxt();
        bus.in_flit = t2;
        nxt();
        chk("s2_tail_flit", bus.fwd_flit, t2);
        chk("s2_tail_port", bus.fwd_port, 2);
        chk("s2_tail_pop", bus.in_ready, 1);
        nxt();
        bus.in_valid = 1'b0; bus.fwd_ready = 1'b0;
        #1;
        chk("s2_idle", busy, 0);

        // MULTABS fork, ej accepted first, fwd two cycles later
        nxt();
        bus.in_valid = 1'b1; bus.in_flit = h3;
        dec(3'd3, MULTABS, 16'h0020);
        nxt();
        bus.ej_ready = 1'b1;
        #1;
        chk("s3_fwd_valid", bus.fwd_valid, 1);
        chk("s3_ej_valid", bus.ej_valid, 1);
        chk("s3_fwd_flit", bus.fwd_flit, h3f);
        chk("s3_ej_flit", bus.ej_flit, h3);
        chk("s3_port", bus.fwd_port, 3);
        chk("s3_n1_ready", bus.in_ready, 0);
        nxt();
        bus.ej_ready = 1'b0;
        #1;
        chk("s3_ej_drop", bus.ej_valid, 0);
        chk("s3_fwd_hold", bus.fwd_valid, 1);
        chk("s3_n2_ready", bus.in_ready, 0);
        chk("s3_n2_busy", busy, 1);
        nxt();
        bus.fwd_ready = 1'b1;
        #1;
        chk("s3_n3_pop", bus.in_ready, 1);
        nxt();
        bus.in_valid = 1'b0; bus.fwd_ready = 1'b0;
        #1;
        chk("s3_idle", busy, 0);
        chk("s3_fwd_clear", bus.fwd_valid, 0);

        // MULTABS absorb only
        nxt();
        bus.in_valid = 1'b1; bus.in_flit = h4; bus.fwd_ready = 1'b1; bus.ej_ready = 1'b1;
        dec(3'd6, MULTABS, 16'h0000);
        nxt();
        chk("s4_ej_valid", bus.ej_valid, 1);
        chk("s4_fwd_valid", bus.fwd_valid, 0);
        chk("s4_ej_flit", bus.ej_flit, h4);
        chk("s4_pop", bus.in_ready, 1);
        nxt();
        bus.in_valid = 1'b0; bus.fwd_ready = 1'b0; bus.ej_ready = 1'b0;
        #1;
        chk("s4_fwd_never", bus.fwd_valid, 0);
        chk("s4_ej_end", bus.ej_valid, 0);
        chk("s4_idle", busy, 0);

        // Body flit in IDLE
        nxt();
        bus.in_valid = 1'b1; bus.in_flit = b5;
        dec(3'd0, UNICAST, 16'h0);
        #1;
        chk("s5_err_pre", err, 0);
        chk("s5_ready_pre", bus.in_ready, 0);
        nxt();
        chk("s5_drop_pop", bus.in_ready, 1);
        chk("s5_err", err, 1);
        chk("s5_busy", busy, 0);
        nxt();
        bus.in_valid = 1'b0;
        #1;
        chk("s5_ready_after", bus.in_ready, 0);
        chk("s5_err_sticky", err, 1);

        // Head arriving mid-packet
        nxt();
        bus.in_valid = 1'b1; bus.in_flit = h5; bus.fwd_ready = 1'b1;
        dec(3'd4, UNICAST, 16'h0);
        nxt();
        chk("s5h_port", bus.fwd_port, 4);
        nxt();
        bus.in_flit = h5b;
        dec(3'd6, MULTFWD, 16'h00AA);
        nxt();
        chk("s5h_valid", bus.fwd_valid, 1);
        chk("s5h_port_kept", bus.fwd_port, 4);
        chk("s5h_flit", bus.fwd_flit, h5b);
        chk("s5h_pop", bus.in_ready, 1);
        nxt();
        bus.in_flit = t5;
        nxt();
        chk("s5h_tail_flit", bus.fwd_flit, t5);
        nxt();
        bus.in_valid = 1'b0; bus.fwd_ready = 1'b0;
        #1;
        chk("s5h_idle", busy, 0);
        chk("s5h_err", err, 1);

        // Reset during BODY
        nxt();
        bus.in_valid = 1'b1; bus.in_flit = h6; bus.fwd_ready = 1'b1;
        dec(3'd1, UNICAST, 16'h0);
        nxt();
        nxt();
        bus.in_flit = b6; bus.fwd_ready = 1'b0;
        nxt();
        chk("s6_body_valid", bus.fwd_valid, 1);
        chk("s6_body_flit", bus.fwd_flit, b6);
        rst_ = 1'b0;
        #1;
        chk("s6_rst_fwd_valid", bus.fwd_valid, 0);
        chk("s6_rst_ej_valid", bus.ej_valid, 0);
        chk("s6_rst_in_ready", bus.in_ready, 0);
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_port", bus.fwd_port, 0);
        chk("s6_rst_flit", bus.fwd_flit, 0);
        chk("s6_rst_err", err, 0);
        bus.in_flit = h6b; bus.fwd_ready = 1'b1;
        dec(3'd7, UNICAST, 16'h0);
        nxt();
        rst_ = 1'b1;
        #1;
        chk("s6_rel_ready", bus.in_ready, 0);
        nxt();
        chk("s6_new_valid", bus.fwd_valid, 1);
        chk("s6_new_port", bus.fwd_port, 7);
        chk("s6_new_flit", bus.fwd_flit, h6b);
        chk("s6_new_pop", bus.in_ready, 1);
        nxt();
        bus.in_valid = 1'b0; bus.fwd_ready = 1'b0;
        #1;
        chk("s6_idle", busy, 0);
        chk("s6_err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
